// File: rtl/ucode_seq_pkg.sv
// ucode_seq_pkg: shared definitions for the microcode sequencer.
//   uctl_e   - encodings of the microword sequencing field (u_ctl)
//   state_e  - sequencer FSM states
//   br_offset- next-address increment selected by the branch bits
package ucode_seq_pkg;

    typedef enum logic [2:0] {
        UC_NEXT = 3'd0,
        UC_BR   = 3'd1,
        UC_JUMP = 3'd2,
        UC_CALL = 3'd3,
        UC_RET  = 3'd4,
        UC_DONE = 3'd5
    } uctl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // br_sel 2 -> +2, br_sel 3 -> +3, anything else falls through (+1).
    function automatic logic [1:0] br_offset(input logic [1:0] br_sel);
        logic [1:0] off;
        off = 2'd1;
        if (br_sel == 2'd2) off = 2'd2;
        if (br_sel == 2'd3) off = 2'd3;
        return off;
    endfunction

endpackage

// File: rtl/ucode_seq_if.sv
// ucode_seq_if: bundle between the sequencer, the R-stage decoder/IU control
// and the microcode ROM.
//   start_valid/start_addr - entry request from the decoder
//   trap_r, hold           - IU trap request and pipeline stall
//   u_ctl/br_sel/u_target  - sequencing field of the current microword
//   rom_addr               - registered ROM address
//   busy/done/stack_err    - sequencer status
// master = sequencer side, slave = decoder/ROM/IU side.
interface ucode_seq_if #(
    parameter int ADDR_W = 9
);
    logic              start_valid;
    logic [ADDR_W-1:0] start_addr;
    logic              trap_r;
    logic              hold;
    logic [2:0]        u_ctl;
    logic [1:0]        br_sel;
    logic [ADDR_W-1:0] u_target;
    logic [ADDR_W-1:0] rom_addr;
    logic              busy;
    logic              done;
    logic              stack_err;

    modport master (
        input  start_valid, start_addr, trap_r, hold, u_ctl, br_sel, u_target,
        output rom_addr, busy, done, stack_err
    );

    modport slave (
        output start_valid, start_addr, trap_r, hold, u_ctl, br_sel, u_target,
        input  rom_addr, busy, done, stack_err
    );
endinterface

// File: rtl/ucode_ret_stack.sv
// ucode_ret_stack: LIFO of return addresses for microcode CALL/RET.
//   clk, reset_l   - clock, asynchronous active-low reset (empties the stack)
//   push/din       - push din (ignored when full)
//   pop            - discard top entry (ignored when empty)
//   clr            - empty the stack, overrides push/pop
//   dout           - current top of stack (0 when empty)
//   full/empty     - occupancy flags
module ucode_ret_stack #(
    parameter int ADDR_W  = 9,
    parameter int STACK_D = 4
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              push,
    input  logic              pop,
    input  logic              clr,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int CNT_W = $clog2(STACK_D + 1);
    localparam int PTR_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [ADDR_W-1:0] mem [STACK_D];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_idx, top_idx;

    assign full    = (count_q == CNT_W'(STACK_D));
    assign empty   = (count_q == '0);
    assign wr_idx  = PTR_W'(count_q);
    assign top_idx = PTR_W'(count_q - CNT_W'(1));
    assign dout    = empty ? '0 : mem[top_idx];

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (push && !full)
            count_d = count_q + CNT_W'(1);
        else if (pop && !empty)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) count_q <= '0;
        else          count_q <= count_d;
    end

    // Storage needs no reset: entries above the count are never read.
    always_ff @(posedge clk) begin
        if (push && !full && !clr)
            mem[wr_idx] <= din;
    end
endmodule

// File: rtl/ucode_seq.sv
// ucode_seq: microcode sequencer owning the ROM address register.
//   clk, reset_l - clock, asynchronous active-low reset
//   bus (master) - decoder entry, trap/hold, microword sequencing field in;
//                  registered rom_addr, busy, done, stack_err out
// IDLE parks on DEFAULT_ADDR until a trap or start; RUN walks the microcode
// using u_ctl (NEXT/BR/JUMP/CALL/RET/DONE) with a hardware return stack.
module ucode_seq
    import ucode_seq_pkg::*;
#(
    parameter int                ADDR_W       = 9,
    parameter int                STACK_D      = 4,
    parameter logic [ADDR_W-1:0] DEFAULT_ADDR = '0,
    parameter logic [ADDR_W-1:0] TRAP_ADDR    = ADDR_W'(9'h1f0)
) (
    input logic         clk,
    input logic         reset_l,
    ucode_seq_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              stk_push, stk_pop, stk_clr;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full, stk_empty;

    ucode_ret_stack #(.ADDR_W(ADDR_W), .STACK_D(STACK_D)) u_ret_stack (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (stk_push),
        .pop     (stk_pop),
        .clr     (stk_clr),
        .din     (addr_q + ADDR_W'(1)),
        .dout    (stk_dout),
        .full    (stk_full),
        .empty   (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        done_d   = 1'b0;      // pulse only; never stretched by hold
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        if (!bus.hold) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.trap_r || bus.start_valid) begin
                        addr_d  = bus.trap_r ? TRAP_ADDR : bus.start_addr;
                        state_d = ST_RUN;
                        err_d   = 1'b0;
                        // A failed CALL leaves stale entries; a new routine
                        // must not return into them.
                        stk_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.trap_r) begin
                        addr_d  = TRAP_ADDR;
                        stk_clr = 1'b1;
                    end else begin
                        case (uctl_e'(bus.u_ctl))
                            UC_BR:   addr_d = addr_q + ADDR_W'(br_offset(bus.br_sel));
                            UC_JUMP: addr_d = bus.u_target;
                            UC_CALL: begin
                                if (stk_full) begin
                                    err_d   = 1'b1;
                                    state_d = ST_IDLE;
                                    addr_d  = DEFAULT_ADDR;
                                end else begin
                                    stk_push = 1'b1;
                                    addr_d   = bus.u_target;
                                end
                            end
                            UC_RET: begin
                                if (stk_empty) begin
                                    err_d   = 1'b1;
                                    state_d = ST_IDLE;
                                    addr_d  = DEFAULT_ADDR;
                                end else begin
                                    stk_pop = 1'b1;
                                    addr_d  = stk_dout;
                                end
                            end
                            UC_DONE: begin
                                done_d  = 1'b1;
                                stk_clr = 1'b1;
                                if (bus.start_valid) begin
                                    addr_d = bus.start_addr;   // back-to-back entry
                                end else begin
                                    state_d = ST_IDLE;
                                    addr_d  = DEFAULT_ADDR;
                                end
                            end
                            default: addr_d = addr_q + ADDR_W'(1);   // NEXT, 6, 7
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            addr_q  <= DEFAULT_ADDR;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.rom_addr  = addr_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = done_q;
    assign bus.stack_err = err_q;
endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: directed bench for ucode_seq (ADDR_W=9, STACK_D=4,
// DEFAULT_ADDR=0, TRAP_ADDR=0x1f0) with hand-computed expected values.
module tb_ucode_seq;
    localparam logic [2:0] NEXT = 3'd0, BR = 3'd1, JUMP = 3'd2,
                           CALL = 3'd3, RET = 3'd4, DONE = 3'd5;

    logic clk;
    logic reset_l;
    int   n_tests;
    int   n_fail;

    ucode_seq_if #(.ADDR_W(9)) bus_if ();

    ucode_seq #(
        .ADDR_W       (9),
        .STACK_D      (4),
        .DEFAULT_ADDR (9'h000),
        .TRAP_ADDR    (9'h1f0)
    ) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] rom, input logic busy,
                           input logic done, input logic err);
        chk({tag, ".rom"},  32'(bus_if.rom_addr),  32'(rom));
        chk({tag, ".busy"}, 32'(bus_if.busy),      32'(busy));
        chk({tag, ".done"}, 32'(bus_if.done),      32'(done));
        chk({tag, ".err"},  32'(bus_if.stack_err), 32'(err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus_if.start_valid = 1'b0;
        bus_if.start_addr  = '0;
        bus_if.trap_r      = 1'b0;
        bus_if.hold        = 1'b0;
        bus_if.u_ctl       = NEXT;
        bus_if.br_sel      = 2'd0;
        bus_if.u_target    = '0;
    endtask

    task automatic start(input logic [8:0] a);
        quiet();
        bus_if.start_valid = 1'b1;
        bus_if.start_addr  = a;
        tick();
        $display("[TB] start 0x%03h -> rom=0x%03h busy=%0b", a, bus_if.rom_addr, bus_if.busy);
        quiet();
    endtask

    task automatic op(input logic [2:0] ctl, input logic [1:0] sel, input logic [8:0] tgt);
        quiet();
        bus_if.u_ctl    = ctl;
        bus_if.br_sel   = sel;
        bus_if.u_target = tgt;
        tick();
        $display("[TB] u_ctl=%0d br_sel=%0d tgt=0x%03h -> rom=0x%03h busy=%0b done=%0b err=%0b",
                 ctl, sel, tgt, bus_if.rom_addr, bus_if.busy, bus_if.done, bus_if.stack_err);
        quiet();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        quiet();
        reset_l = 1'b0;
        #3;
        chk_all("reset", 9'h000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_l = 1'b1;

        // Basic run: NEXT, NEXT, DONE
        start(9'h040);              chk_all("st40", 9'h040, 1, 0, 0);
        op(NEXT, 0, 0);             chk_all("nx1",  9'h041, 1, 0, 0);
        op(NEXT, 0, 0);             chk_all("nx2",  9'h042, 1, 0, 0);
        op(DONE, 0, 0);             chk_all("done", 9'h000, 0, 1, 0);
        op(NEXT, 0, 0);             chk_all("idle", 9'h000, 0, 0, 0);

        // Branch fan-out and wrap
        start(9'h100);
        op(BR, 2'd3, 0);            chk("br3", 32'(bus_if.rom_addr), 32'h103);
        op(JUMP, 0, 9'h100);        chk("jmp", 32'(bus_if.rom_addr), 32'h100);
        op(BR, 2'd2, 0);            chk("br2", 32'(bus_if.rom_addr), 32'h102);
        op(JUMP, 0, 9'h100);
        op(BR, 2'd1, 0);            chk("br1", 32'(bus_if.rom_addr), 32'h101);
        op(BR, 2'd0, 0);            chk("br0", 32'(bus_if.rom_addr), 32'h102);
        op(JUMP, 0, 9'h1ff);
        op(NEXT, 0, 0);             chk("wrap", 32'(bus_if.rom_addr), 32'h000);
        op(3'd7, 0, 0);             chk("uc7", 32'(bus_if.rom_addr), 32'h001);
        op(DONE, 0, 0);

        // Nested call/return, then RET on empty stack
        start(9'h080);
        op(CALL, 0, 9'h150);        chk_all("call1", 9'h150, 1, 0, 0);
        op(NEXT, 0, 0);
        op(CALL, 0, 9'h160);        chk_all("call2", 9'h160, 1, 0, 0);
        op(RET, 0, 0);              chk_all("ret1",  9'h152, 1, 0, 0);
        op(RET, 0, 0);              chk_all("ret2",  9'h081, 1, 0, 0);
        op(RET, 0, 0);              chk_all("retE",  9'h000, 0, 0, 1);
        op(NEXT, 0, 0);             chk_all("errS",  9'h000, 0, 0, 1);
        start(9'h081);              chk_all("clrE",  9'h081, 1, 0, 0);

        // Overflow on the fifth nested CALL
        op(CALL, 0, 9'h010);
        op(CALL, 0, 9'h020);
        op(CALL, 0, 9'h030);
        op(CALL, 0, 9'h040);        chk_all("call4", 9'h040, 1, 0, 0);
        op(CALL, 0, 9'h050);        chk_all("ovf",   9'h000, 0, 0, 1);
        start(9'h070);              chk_all("clrO",  9'h070, 1, 0, 0);
        op(DONE, 0, 0);             chk_all("doneO", 9'h000, 0, 1, 0);

        // Hold freezes everything, including start/trap requests
        start(9'h030);
        op(NEXT, 0, 0);             chk("pre_hold", 32'(bus_if.rom_addr), 32'h031);
        for (int i = 0; i < 3; i++) begin
            bus_if.hold        = 1'b1;
            bus_if.u_ctl       = 3'(i + 2);      // JUMP, CALL, RET
            bus_if.u_target    = 9'h1aa;
            bus_if.trap_r      = (i == 1);
            bus_if.start_valid = 1'b1;
            bus_if.start_addr  = 9'h0aa;
            tick();
            $display("[TB] hold u_ctl=%0d -> rom=0x%03h busy=%0b", bus_if.u_ctl,
                     bus_if.rom_addr, bus_if.busy);
            chk_all($sformatf("hold%0d", i), 9'h031, 1, 0, 0);
        end
        op(NEXT, 0, 0);             chk("resume", 32'(bus_if.rom_addr), 32'h032);

        // Trap beats CALL and empties the stack
        op(CALL, 0, 9'h100);        chk("callT", 32'(bus_if.rom_addr), 32'h100);
        bus_if.trap_r   = 1'b1;
        bus_if.u_ctl    = CALL;
        bus_if.u_target = 9'h150;
        tick();
        $display("[TB] trap+CALL -> rom=0x%03h", bus_if.rom_addr);
        quiet();
        chk_all("trapC", 9'h1f0, 1, 0, 0);
        op(RET, 0, 0);              chk_all("trapE", 9'h000, 0, 0, 1);

        // Back-to-back DONE/start; done not stretched by hold
        start(9'h010);
        bus_if.u_ctl       = DONE;
        bus_if.start_valid = 1'b1;
        bus_if.start_addr  = 9'h020;
        tick();
        $display("[TB] DONE+start -> rom=0x%03h done=%0b", bus_if.rom_addr, bus_if.done);
        quiet();
        chk_all("b2b", 9'h020, 1, 1, 0);
        op(NEXT, 0, 0);             chk_all("b2b_n", 9'h021, 1, 0, 0);
        op(DONE, 0, 0);             chk_all("done2", 9'h000, 0, 1, 0);
        bus_if.hold = 1'b1;
        tick();
        $display("[TB] hold after DONE -> done=%0b", bus_if.done);
        quiet();
        chk_all("dhold", 9'h000, 0, 0, 0);

        // Trap from IDLE, trap beats DONE, then async reset mid-run
        bus_if.trap_r = 1'b1;
        tick();
        $display("[TB] idle trap -> rom=0x%03h", bus_if.rom_addr);
        quiet();
        chk_all("itrap", 9'h1f0, 1, 0, 0);
        bus_if.trap_r = 1'b1;
        bus_if.u_ctl  = DONE;
        tick();
        $display("[TB] trap+DONE -> rom=0x%03h done=%0b", bus_if.rom_addr, bus_if.done);
        quiet();
        chk_all("trapD", 9'h1f0, 1, 0, 0);
        op(NEXT, 0, 0);             chk("trapN", 32'(bus_if.rom_addr), 32'h1f1);
        reset_l = 1'b0;
        #1;
        $display("[TB] async reset -> rom=0x%03h busy=%0b", bus_if.rom_addr, bus_if.busy);
        chk_all("areset", 9'h000, 0, 0, 0);
        #2;
        reset_l = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
